hanoi_solver: RTL
=================

Name: hanoi_solver

Overview:
Move generator for the Tower of Hanoi puzzle tracker: it produces the optimal iterative move sequence (ring index, destination stick) that the tracker consumes. It keeps its own copy of ring locations and a move counter, and presents one move per handshake. It stops after 2^N-1 moves, when all rings are on stick M-1.

Parameters:
N, 16, number of rings; ring 0 is the smallest; N >= 2
M, 3, number of sticks; the rotation rule is optimal only for M = 3; other values are legal but unverified
IW, $clog2(N), ring index width (localparam)
LW, $clog2(M), stick index width (localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a solve; honoured in IDLE and DONE only
mv_valid  out  1  a move is presented
mv_ready  in  1  consumer accepts the move
mv_ind  out  IW  ring to move
mv_loc  out  LW  destination stick
rings  out  N*LW  current location of each ring; ring i at [(i+1)*LW-1 -: LW]
move_cnt  out  N  number of moves accepted so far
busy  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state IDLE; rings all 0; internal counter ctr = 1; move_cnt = 0; mv_valid = 0; busy = 0; done = 0.
- IDLE: start=1 -> RUN next cycle; rings cleared to 0; ctr = 1; move_cnt = 0. mv_valid rises the cycle after start is sampled.
- RUN: mv_valid = 1 every cycle.
  - mv_ind = count of trailing zeros of ctr, i.e. the largest i with ctr mod 2^i == 0.
  - old = rings[mv_ind].
  - If (N - mv_ind) is odd, go left: mv_loc = (old == 0) ? M-1 : old-1.
  - Otherwise go right: mv_loc = (old == M-1) ? 0 : old+1.
  - mv_ind and mv_loc are combinational from registered ctr and rings, so they are stable while mv_valid && !mv_ready.
- Accept (mv_valid && mv_ready, same edge):
  - rings[mv_ind] <= mv_loc;
  - ctr <= ctr + 1;
  - move_cnt <= move_cnt + 1.
  - One move per cycle is sustainable with mv_ready held high.
- Termination: the accept with ctr == 2^N-1 (all ones) moves to DONE. mv_valid is low from the next cycle. move_cnt = 2^N-1 and rings all equal M-1 (for M = 3).
- mv_valid is never retracted before acceptance. start is ignored in RUN.
- DONE: done = 1; outputs hold. start=1 -> same action as in IDLE (restart from stick 0).
- rst asserted mid-RUN: next cycle is the reset state; a pending move is dropped with no partial update.
- Counter width: ctr is N bits and never wraps, because termination precedes overflow.

Optional Feature:
HANOI_SOLVER_CHECK_EN
- Defined: embedded concurrent properties, disabled by rst, on the default clocking @(posedge clk):
  - every accepted move is legal: no ring j < mv_ind has rings[j] == rings[mv_ind] or rings[j] == mv_loc;
  - mv_loc != rings[mv_ind];
  - mv_valid && !mv_ready |=> $stable({mv_ind, mv_loc});
  - cover: done reached.
- Undefined: no properties; functionality identical.

Decomposition:
- Package hanoi_pkg:
  - state enum (IDLE/RUN/DONE);
  - ring_idx_t and stick_t typedef widths, as functions of N and M;
  - function final_rings(N, M) returning all M-1, for the done/cover check.
- Sub-module hanoi_next_move: purely combinational, (ctr, rings) -> (ind, loc). The puzzle tracker's formal environment reuses it.

Test Plan:
- N=3, start, mv_ready=1 -> accepted (ind, loc) = (0,2),(1,1),(0,1),(2,2),(0,0),(1,2),(0,2); done one cycle after the 7th accept; rings = 3'b{2,2,2} packed 6'b101010; move_cnt = 7.
- N=3, mv_ready low for 3 cycles on move 2 -> mv_valid=1 throughout, mv_ind=1 and mv_loc=1 stable, rings unchanged until the accept.
- N=4, random mv_ready -> exactly 15 accepts; final rings 8'hAA; no illegal move flagged with HANOI_SOLVER_CHECK_EN.
- N=3, rst after 4th accept -> next cycle rings=0, move_cnt=0, mv_valid=0, state IDLE; restart yields the full sequence again.
- DONE then start -> rings cleared, first move (0,2) presented the following cycle; start pulsed in RUN -> no effect on the sequence.

Source files
------------

// File: rtl/hanoi_pkg.sv
// hanoi_pkg: shared state encoding, index types and final-position helper for the Hanoi solver
package hanoi_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N_DEF = 16;
  localparam int M_DEF = 3;
  localparam int FR_W = 256;
  typedef logic [$clog2(N_DEF)-1:0] ring_idx_t;
  typedef logic [$clog2(M_DEF)-1:0] stick_t;
  function automatic logic [FR_W-1:0] final_rings(input int n, input int m);
    int lw;
    lw = $clog2(m);
    final_rings = '0;
    for (int i = 0; i < n * lw; i++)
      if ((((m - 1) >> (i % lw)) & 1) != 0) final_rings[i] = 1'b1;
  endfunction
endpackage

// File: rtl/hanoi_next_move.sv
// hanoi_next_move: combinational (ctr, rings) -> next optimal move (ring, destination stick)
module hanoi_next_move #(
  parameter int N = 16,
  parameter int M = 3,
  localparam int IW = $clog2(N),
  localparam int LW = $clog2(M)
) (
  input  logic [N-1:0]    ctr,
  input  logic [N*LW-1:0] rings,
  output logic [IW-1:0]   ind,
  output logic [LW-1:0]   loc
);
  logic [LW-1:0] old;
  logic left;
  // ring = trailing zeros of ctr; direction alternates with ring parity relative to N
  always_comb begin
    ind = '0;
    for (int i = N - 1; i >= 0; i--) if (ctr[i]) ind = IW'(i);
    old = rings[ind*LW +: LW];
    left = ((N % 2) == 1) ^ ind[0];
    loc = left ? ((old == '0) ? LW'(M - 1) : old - 1'b1)
               : ((old == LW'(M - 1)) ? '0 : old + 1'b1);
  end
endmodule

// File: rtl/hanoi_solver.sv
// hanoi_solver: iterative Tower of Hanoi move generator with valid/ready handshake (optional checks: HANOI_SOLVER_CHECK_EN)
module hanoi_solver
  import hanoi_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 3,
  localparam int IW = $clog2(N),
  localparam int LW = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            mv_valid,
  input  logic            mv_ready,
  output logic [IW-1:0]   mv_ind,
  output logic [LW-1:0]   mv_loc,
  output logic [N*LW-1:0] rings,
  output logic [N-1:0]    move_cnt,
  output logic            busy,
  output logic            done
);
  state_t state_q, state_d;
  logic [N-1:0] ctr_q, ctr_d, cnt_q, cnt_d;
  logic [N*LW-1:0] rings_q, rings_d;
  logic acc;
  hanoi_next_move #(.N(N), .M(M)) u_next_move (
    .ctr(ctr_q), .rings(rings_q), .ind(mv_ind), .loc(mv_loc)
  );
  assign mv_valid = state_q == RUN;
  assign acc = mv_valid && mv_ready;
  assign rings = rings_q;
  assign move_cnt = cnt_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  // start (re)initialises the puzzle; each accept applies one move; the all-ones accept finishes
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    cnt_d = cnt_q;
    rings_d = rings_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      ctr_d = N'(1);
      cnt_d = '0;
      rings_d = '0;
    end else if (acc) begin
      rings_d[mv_ind*LW +: LW] = mv_loc;
      ctr_d = (&ctr_q) ? ctr_q : ctr_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
      state_d = (&ctr_q) ? DONE : RUN;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q <= N'(1);
      cnt_q <= '0;
      rings_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      cnt_q <= cnt_d;
      rings_q <= rings_d;
    end
  end
`ifdef HANOI_SOLVER_CHECK_EN
  localparam logic [FR_W-1:0] FINAL = final_rings(N, M);
  logic [LW-1:0] old;
  logic legal;
  // a move is legal when no smaller ring sits on the source or destination stick
  always_comb begin
    old = rings_q[mv_ind*LW +: LW];
    legal = 1'b1;
    for (int j = 0; j < N; j++)
      if (j < int'(mv_ind) && (rings_q[j*LW +: LW] == old || rings_q[j*LW +: LW] == mv_loc)) legal = 1'b0;
  end
  default clocking cb @(posedge clk); endclocking
  default disable iff (rst);
  a_legal: assert property (acc |-> legal);
  a_moves: assert property (mv_valid |-> mv_loc != old);
  a_stable: assert property (mv_valid && !mv_ready |=> $stable({mv_ind, mv_loc}));
  c_done: cover property (done && rings_q == FINAL[N*LW-1:0]);
`endif
endmodule
